// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised single-port RAM.
package ram_pkg;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   localparam logic [7:0] LOCK0_DEFAULT = 8'hF3;

endpackage

// File: rtl/ram_param_if.sv
// Request/response bundle between the load/store control and ram_param.
// Handshake: requests (we, rd) are honoured only on edges where ready=1;
// rd_valid pulses for one cycle after each accepted rd, dataOut holds that word.
interface ram_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) ();
   import ram_pkg::*;

   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] dataIn;
   logic              we;
   logic              rd;
   logic [DATA_W-1:0] dataOut;
   logic              rd_valid;
   logic              ready;
   state_t            state;

   modport master (
      output address, dataIn, we, rd,
      input  dataOut, rd_valid, ready, state
   );

   modport slave (
      input  address, dataIn, we, rd,
      output dataOut, rd_valid, ready, state
   );
endinterface

// File: rtl/ram_init_ctrl.sv
// Post-reset clear sweep: walks every address once, then stays in RUN.
module ram_init_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              ready,
   output logic              init_we,
   output logic [ADDR_W-1:0] init_addr,
   output state_t            state
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      init_we = 1'b0;
      ready   = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_we = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            // Terminal count is all-ones; the wrap back to 0 is harmless.
            if (cnt_q == '1) state_d = ST_RUN;
         end
         ST_RUN: begin
            ready = 1'b1;
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign init_addr = cnt_q;
   assign state     = state_q;

endmodule

// File: rtl/ram_param.sv
// Parametrised single-port RAM with post-reset clear, 1-cycle read latency,
// selectable read-during-write and an optional read-only word 0.
module ram_param
   import ram_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter int                ADDR_W      = 4,
   parameter logic [DATA_W-1:0] INIT_VALUE  = '0,
   parameter int                RDW_MODE    = RDW_OLD,
   parameter int                LOCK0       = 1,
   parameter logic [DATA_W-1:0] LOCK0_VALUE = DATA_W'(LOCK0_DEFAULT)
) (
   input logic         clock,
   input logic         reset_n,
   ram_param_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              ready;
   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   state_t            state;

   ram_init_ctrl #(.ADDR_W(ADDR_W)) u_init_ctrl (
      .clock     (clock),
      .reset_n   (reset_n),
      .ready     (ready),
      .init_we   (init_we),
      .init_addr (init_addr),
      .state     (state)
   );

   logic              locked;
   logic              user_we;
   logic              user_rd;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;

   assign locked  = (LOCK0 != 0) && (bus.address == '0);
   assign user_we = ready && bus.we && !locked;
   assign user_rd = ready && bus.rd;

   // The sweep owns the write port while it runs; user requests are dropped.
   always_comb begin
      wr_en   = user_we;
      wr_addr = bus.address;
      wr_data = bus.dataIn;
      if (init_we) begin
         wr_en   = 1'b1;
         wr_addr = init_addr;
         wr_data = INIT_VALUE;
      end
   end

   always_comb begin
      rd_data = mem[bus.address];
      if (RDW_MODE == RDW_NEW && bus.we) rd_data = bus.dataIn;
      if (locked) rd_data = LOCK0_VALUE;
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.dataOut  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= user_rd;
         if (user_rd) bus.dataOut <= rd_data;
      end
   end

   assign bus.ready = ready;
   assign bus.state = state;

endmodule

// File: tb/tb_ram_param.sv
// Bench for ram_param: two instances (old-data/locked and write-through/unlocked)
// driven in lockstep and checked against a behavioural memory model.
module tb_ram_param;
   import ram_pkg::*;

   localparam int DEPTH = 16;

   logic clock;
   logic reset_n;

   ram_param_if #(.DATA_W(8), .ADDR_W(4)) bus_a ();
   ram_param_if #(.DATA_W(8), .ADDR_W(4)) bus_b ();

   ram_param #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0), .LOCK0(1)) dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_a)
   );

   ram_param #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(1), .LOCK0(0)) dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus_b)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // reference model: index 0 = dut_a, index 1 = dut_b
   int         lock0_c [2] = '{1, 0};
   int         rdw_c   [2] = '{0, 1};
   logic [7:0] mem_m   [2][DEPTH];
   logic [7:0] exp_dout[2];
   logic       exp_valid;
   logic       m_run;
   int         m_cnt;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run       = 1'b0;
      m_cnt       = 0;
      exp_valid   = 1'b0;
      exp_dout[0] = 8'h00;
      exp_dout[1] = 8'h00;
   endtask

   task automatic model_edge(input logic we, input logic rd, input logic [3:0] a, input logic [7:0] d);
      if (!m_run) begin
         exp_valid = 1'b0;
         m_cnt++;
         if (m_cnt == DEPTH) begin
            m_run = 1'b1;
            for (int c = 0; c < 2; c++)
               for (int i = 0; i < DEPTH; i++) mem_m[c][i] = 8'h00;
         end
      end else begin
         exp_valid = rd;
         for (int c = 0; c < 2; c++) begin
            logic lk;
            lk = (lock0_c[c] != 0) && (a == 4'd0);
            if (rd) begin
               if (lk)                       exp_dout[c] = 8'hF3;
               else if (we && rdw_c[c] != 0) exp_dout[c] = d;
               else                          exp_dout[c] = mem_m[c][a];
            end
            if (we && !lk) mem_m[c][a] = d;
         end
      end
   endtask

   task automatic drive(input logic we, input logic rd, input logic [3:0] a, input logic [7:0] d);
      bus_a.we = we;  bus_a.rd = rd;  bus_a.address = a;  bus_a.dataIn = d;
      bus_b.we = we;  bus_b.rd = rd;  bus_b.address = a;  bus_b.dataIn = d;
   endtask

   task automatic check_outputs();
      chk("ready_a",    {7'd0, bus_a.ready},    {7'd0, m_run});
      chk("ready_b",    {7'd0, bus_b.ready},    {7'd0, m_run});
      chk("rd_valid_a", {7'd0, bus_a.rd_valid}, {7'd0, exp_valid});
      chk("rd_valid_b", {7'd0, bus_b.rd_valid}, {7'd0, exp_valid});
      chk("dataOut_a",  bus_a.dataOut, exp_dout[0]);
      chk("dataOut_b",  bus_b.dataOut, exp_dout[1]);
   endtask

   // One clock: inputs applied, edge taken, outputs checked 1 ns later.
   task automatic cycle(input logic we, input logic rd, input logic [3:0] a, input logic [7:0] d);
      drive(we, rd, a, d);
      @(posedge clock);
      model_edge(we, rd, a, d);
      #1;
      check_outputs();
   endtask

   // Short low pulse just after an edge; outputs must clear without a clock.
   task automatic pulse_reset();
      drive(1'b0, 1'b0, 4'd0, 8'h00);
      #1 reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      #2 reset_n = 1'b1;
   endtask

   typedef struct {
      logic       we;
      logic       rd;
      logic [3:0] a;
      logic [7:0] d;
      logic       v;
      logic [7:0] qa;
      logic [7:0] qb;
   } vec_t;

   vec_t tbl[8];

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 4'd0, 8'h00);
      model_reset();
      @(posedge clock);
      #1;
      pulse_reset();

      // Sweep: requests during INIT must be dropped, ready rises on edge 16.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 4'd2, 8'h99);
      chk("ready_after_sweep", {7'd0, bus_a.ready}, 8'd1);

      // Every word cleared, including address 2 despite the dropped write.
      for (int i = 1; i < DEPTH; i++) begin
         cycle(1'b0, 1'b1, i[3:0], 8'h00);
         chk("sweep_read", bus_b.dataOut, 8'h00);
      end
      cycle(1'b0, 1'b0, 4'd0, 8'h00);

      tbl[0] = '{1'b1, 1'b0, 4'd3, 8'hA5, 1'b0, 8'h00, 8'h00};
      tbl[1] = '{1'b0, 1'b1, 4'd3, 8'h00, 1'b1, 8'hA5, 8'hA5};
      tbl[2] = '{1'b1, 1'b0, 4'd0, 8'h11, 1'b0, 8'h00, 8'h00};
      tbl[3] = '{1'b0, 1'b1, 4'd0, 8'h00, 1'b1, 8'hF3, 8'h11};
      tbl[4] = '{1'b1, 1'b0, 4'd5, 8'h22, 1'b0, 8'h00, 8'h00};
      tbl[5] = '{1'b1, 1'b1, 4'd5, 8'h77, 1'b1, 8'h22, 8'h77};
      tbl[6] = '{1'b0, 1'b1, 4'd5, 8'h00, 1'b1, 8'h77, 8'h77};
      tbl[7] = '{1'b1, 1'b1, 4'd0, 8'h3C, 1'b1, 8'hF3, 8'h3C};
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].we, tbl[i].rd, tbl[i].a, tbl[i].d);
         chk("tbl_valid", {7'd0, bus_a.rd_valid}, {7'd0, tbl[i].v});
         if (tbl[i].v) begin
            exp_q.push_back(tbl[i].qa);
            exp_q.push_back(tbl[i].qb);
            chk("tbl_dout_a", bus_a.dataOut, exp_q.pop_front());
            chk("tbl_dout_b", bus_b.dataOut, exp_q.pop_front());
         end
      end

      // Random traffic against the model, back-to-back reads included.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
               4'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)));
      end

      // Reset in the middle of a read stream; word 9 must come back cleared.
      cycle(1'b1, 1'b0, 4'd9, 8'h5A);
      cycle(1'b0, 1'b1, 4'd9, 8'h00);
      chk("pre_reset_read", bus_a.dataOut, 8'h5A);
      pulse_reset();
      chk("reset_valid_clear", {7'd0, bus_b.rd_valid}, 8'd0);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 4'd9, 8'h00);
      cycle(1'b0, 1'b1, 4'd9, 8'h00);
      chk("post_reset_read_a", bus_a.dataOut, 8'h00);
      chk("post_reset_read_b", bus_b.dataOut, 8'h00);
      cycle(1'b0, 1'b0, 4'd0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
